// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-address decode helper for the regfile_mp block.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [XLEN_DEF-1:0] word_t;
  typedef logic [AW_DEF-1:0]   reg_addr_t;

  // Bit idx of the one-hot decode of addr; called once per register bit.
  function automatic logic onehot_dec(input int addr, input int idx);
    return (addr == idx);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: a reservation sets a bit, a write clears it, and the reservation
// wins when both hit the same register in one cycle.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [NREGS-1:1] clr,
  output logic [NREGS-1:0] pending
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (rsv_valid && (rsv_addr == AW'(r)))
          pending[r] <= 1'b1;
        else if (clr[r])
          pending[r] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero r0, port-1 write priority and a pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREGS-1:0]    pending
);

  // Register 0 has no storage; reads of address 0 fall through to zero.
  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:1] wr_dec [NWR];
  logic [NREGS-1:1] clr_vec;

  for (genvar gi = 0; gi < NWR; gi++) begin : g_dec
    for (genvar gr = 1; gr < NREGS; gr++) begin : g_bit
      assign wr_dec[gi][gr] = we[gi] && onehot_dec(int'(wr_addr[gi*AW +: AW]), gr);
    end
  end

  always_comb begin
    clr_vec = '0;
    for (int j = 0; j < NWR; j++)
      clr_vec = clr_vec | wr_dec[j];
  end

  // Ports are visited in ascending order so the higher-numbered port wins a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 1; r < NREGS; r++)
        regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++)
        for (int j = 0; j < NWR; j++)
          if (wr_dec[j][r])
            regs[r] <= wr_data[j*XLEN +: XLEN];
    end
  end

  regfile_scoreboard #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_valid(rsv_valid),
    .rsv_addr (rsv_addr),
    .clr      (clr_vec),
    .pending  (pending)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;
    logic            busy;

    assign addr = rd_addr[gi*AW +: AW];

    always_comb begin
      val  = '0;
      busy = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (addr == AW'(r)) begin
          val  = regs[r];
          busy = pending[r];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (rst_n) begin
        for (int j = 0; j < NWR; j++) begin
          for (int r = 1; r < NREGS; r++) begin
            if ((addr == AW'(r)) && wr_dec[j][r]) begin
              val  = wr_data[j*XLEN +: XLEN];
              busy = 1'b0;
            end
          end
        end
      end
`endif
    end

    assign rd_data[gi*XLEN +: XLEN] = val;
    assign rd_busy[gi]              = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp (2 read, 2 write ports) against an array-based model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic [NREGS-1:0]    pending;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  int              n_cmp = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_valid(rsv_valid),
    .rsv_addr (rsv_addr),
    .pending  (pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // An accepted write with a matching address this cycle (last port wins); -1 if none.
  function automatic int fwd_port(input int a);
    int p;
    p = -1;
`ifdef REGFILE_BYPASS_EN
    if (rst_n === 1'b1 && a != 0)
      for (int j = 0; j < NWR; j++)
        if (we[j] === 1'b1 && int'(wr_addr[j*AW +: AW]) == a) p = j;
`endif
    return p;
  endfunction

  function automatic logic [31:0] exp_data(input int a);
    int p;
    if (a == 0) return '0;
    p = fwd_port(a);
    if (p >= 0) return wr_data[p*XLEN +: XLEN];
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_busy(input int a);
    if (a == 0 || fwd_port(a) >= 0) return '0;
    return {31'b0, m_pend[a]};
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] v;
    for (int r = 0; r < NREGS; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic model_edge();
    if (rst_n !== 1'b1) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        int a;
        a = int'(wr_addr[j*AW +: AW]);
        if (we[j] === 1'b1 && a != 0) begin
          m_regs[a] = wr_data[j*XLEN +: XLEN];
          m_pend[a] = 1'b0;
        end
      end
      if (rsv_valid && rsv_addr != 0) m_pend[int'(rsv_addr)] = 1'b1;
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 2ns later, then the edge is modelled.
  task automatic tick(input string tag);
    #2;
    $display("[%0t] %s rst_n=%b we=%b wa=%h wd=%h rsv=%b/%0d ra=%h rd=%h busy=%b pend=%h",
             $time, tag, rst_n, we, wr_addr, wr_data, rsv_valid, rsv_addr, rd_addr, rd_data,
             rd_busy, pending);
    for (int p = 0; p < NRD; p++) begin
      int a;
      a = int'(rd_addr[p*AW +: AW]);
      chk($sformatf("%s.data%0d", tag, p), rd_data[p*XLEN +: XLEN], exp_data(a));
      chk($sformatf("%s.busy%0d", tag, p), {31'b0, rd_busy[p]}, exp_busy(a));
    end
    chk($sformatf("%s.pending", tag), pending, exp_pending());
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_in(input logic rst, input logic [1:0] w,
                        input int wa0, input logic [31:0] wd0,
                        input int wa1, input logic [31:0] wd1,
                        input logic rv, input int ra, input int r0, input int r1);
    rst_n     = rst;
    we        = w;
    wr_addr   = {AW'(wa1), AW'(wa0)};
    wr_data   = {wd1, wd0};
    rsv_valid = rv;
    rsv_addr  = AW'(ra);
    rd_addr   = {AW'(r1), AW'(r0)};
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end

    set_in(1'b0, 2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 31);
    repeat (2) @(posedge clk);
    @(negedge clk);

    set_in(1'b1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 31);
    tick("reset_read");

    set_in(1'b1, 2'b01, 10, 14, 0, 0, 1'b0, 0, 10, 10);
    tick("write10");
    set_in(1'b1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 10, 10);
    tick("read10");
    wr_addr = 'x;
    wr_data = 'x;
    tick("xhold_a");
    tick("xhold_b");

    set_in(1'b1, 2'b01, 0, 32'hDEADBEEF, 0, 0, 1'b1, 0, 0, 0);
    tick("r0_write");
    set_in(1'b1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
    tick("r0_read");

    set_in(1'b1, 2'b11, 7, 3, 7, 9, 1'b0, 0, 7, 10);
    tick("collide");
    set_in(1'b1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 7, 7);
    tick("collide_rd");

    set_in(1'b1, 2'b00, 0, 0, 0, 0, 1'b1, 4, 4, 4);
    tick("rsv4");
    set_in(1'b1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 4);
    tick("rsv4_busy");
    set_in(1'b1, 2'b01, 4, 32'h55, 0, 0, 1'b0, 0, 4, 5);
    tick("wr4");
    set_in(1'b1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 4);
    tick("wr4_clear");
    set_in(1'b1, 2'b10, 0, 0, 4, 32'h66, 1'b1, 4, 4, 4);
    tick("rsv_wr4");
    set_in(1'b1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 4);
    tick("rsv_wr4_after");

    set_in(1'b1, 2'b01, 12, 32'h1234, 0, 0, 1'b0, 0, 12, 12);
    tick("bypass12");
    set_in(1'b1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 12, 12);
    tick("bypass12_after");

    set_in(1'b0, 2'b01, 20, 32'hABCD, 0, 0, 1'b1, 20, 20, 12);
    tick("rst_wr20");
    set_in(1'b1, 2'b01, 21, 32'h77, 0, 0, 1'b0, 0, 20, 21);
    tick("after_rst");
    set_in(1'b1, 2'b00, 0, 0, 0, 0, 1'b0, 0, 20, 21);
    tick("after_rst_rd");

    for (int i = 0; i < 250; i++) begin
      int wa0, wa1;
      wa0 = int'($urandom_range(0, NREGS - 1));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : int'($urandom_range(0, NREGS - 1));
      set_in(($urandom_range(0, 40) != 0), 2'($urandom_range(0, 3)),
             wa0, $urandom, wa1, $urandom,
             ($urandom_range(0, 2) == 0), int'($urandom_range(0, NREGS - 1)),
             ($urandom_range(0, 2) == 0) ? wa0 : int'($urandom_range(0, NREGS - 1)),
             ($urandom_range(0, 2) == 0) ? wa1 : int'($urandom_range(0, NREGS - 1)));
      tick($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
